pe_lsb_first: RTL and testbench



---
 rtl/pe_lsb_first_if.sv | 51 +++++
 rtl/pe_lsb_first.sv | 102 ++++++++++
 tb/tb_pe_lsb_first.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pe_lsb_first_if.sv
// pe_lsb_first_if
//   Bundles the request vector and every grant output of the LSB-first
//   priority encoder into one interface.
//
//   Parameter:
//     WIDTH          number of request lines (>= 1)
//   Signals:
//     req_vec        [WIDTH-1:0] request vector, bit i = requester i
//     ack_one_hot    [WIDTH-1:0] combinational one-hot grant
//     ack_valid                  combinational "some request present"
//     ack_index      [IW-1:0]    combinational binary index of the grant
//     ack_one_hot_q  [WIDTH-1:0] registered ack_one_hot
//     ack_valid_q                registered ack_valid
//     ack_index_q    [IW-1:0]    registered ack_index
//   Modports:
//     master  requester side: drives req_vec, observes the grants
//     slave   encoder side: observes req_vec, drives the grants
interface pe_lsb_first_if #(
  parameter int WIDTH = 8
);
  // Index width; a single-line encoder still carries a 1-bit index.
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] req_vec;
  logic [WIDTH-1:0] ack_one_hot;
  logic             ack_valid;
  logic [IW-1:0]    ack_index;
  logic [WIDTH-1:0] ack_one_hot_q;
  logic             ack_valid_q;
  logic [IW-1:0]    ack_index_q;

  modport master (
    output req_vec,
    input  ack_one_hot,
    input  ack_valid,
    input  ack_index,
    input  ack_one_hot_q,
    input  ack_valid_q,
    input  ack_index_q
  );

  modport slave (
    input  req_vec,
    output ack_one_hot,
    output ack_valid,
    output ack_index,
    output ack_one_hot_q,
    output ack_valid_q,
    output ack_index_q
  );
endinterface

// File: rtl/pe_lsb_first.sv
// pe_lsb_first
//   Least-significant-bit-first priority encoder. Grants the lowest-indexed
//   asserted request as a one-hot vector, a binary index and a valid flag.
//   An optional registered copy of the result is available for consumers
//   that need a flop boundary.
//
//   Configuration macro:
//     PE_LSB_FOR_REG_OUT_EN  defined   -> _q outputs are flops, 1-cycle latency,
//                                          cleared asynchronously by nRST
//                            undefined -> no flops, _q outputs tied to 0,
//                                          CLK/nRST unused
//
//   Ports:
//     CLK   clock, used only by the registered outputs
//     nRST  asynchronous active-low reset of the registered outputs
//     bus   pe_lsb_first_if.slave: req_vec in, all grant outputs out
//
//   The combinational outputs never depend on CLK or nRST and stay live
//   while reset is asserted.
module pe_lsb_first #(
  parameter int WIDTH = 8
) (
  input  logic           CLK,
  input  logic           nRST,
  pe_lsb_first_if.slave  bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] one_hot_next;
  logic             valid_next;
  logic [IW-1:0]    index_next;

  // Loop-coded scan from bit 0 upward. Once a set bit is found the
  // remaining bits are never consulted, so bits above the winner (even X)
  // cannot reach the outputs. Equivalent to req & (~req + 1).
  always_comb begin
    logic found;
    one_hot_next = '0;
    found        = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!found && bus.req_vec[i]) begin
        one_hot_next[i] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  assign valid_next = |bus.req_vec;

  // Index bit gb is the OR of the one-hot bits whose position has bit gb
  // set. Because the one-hot is already isolated, no further priority
  // logic is needed and an empty request yields index 0.
  genvar gb, gi;
  generate
    for (gb = 0; gb < IW; gb++) begin : g_idx
      logic [WIDTH-1:0] sel_mask;
      for (gi = 0; gi < WIDTH; gi++) begin : g_mask
        assign sel_mask[gi] = (((gi >> gb) % 2) == 1);
      end
      assign index_next[gb] = |(one_hot_next & sel_mask);
    end
  endgenerate

  assign bus.ack_one_hot = one_hot_next;
  assign bus.ack_valid   = valid_next;
  assign bus.ack_index   = index_next;

`ifdef PE_LSB_FOR_REG_OUT_EN
  logic [WIDTH-1:0] ack_one_hot_reg;
  logic             ack_valid_reg;
  logic [IW-1:0]    ack_index_reg;

  // Free-running capture; no enable, so the _q outputs always show the
  // result for the request present at the previous rising edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ack_one_hot_reg <= '0;
      ack_valid_reg   <= 1'b0;
      ack_index_reg   <= '0;
    end else begin
      ack_one_hot_reg <= one_hot_next;
      ack_valid_reg   <= valid_next;
      ack_index_reg   <= index_next;
    end
  end

  assign bus.ack_one_hot_q = ack_one_hot_reg;
  assign bus.ack_valid_q   = ack_valid_reg;
  assign bus.ack_index_q   = ack_index_reg;
`else
  // Registered copy disabled: outputs are constant and the clock/reset
  // pins are intentionally left without a load.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, CLK, nRST};

  assign bus.ack_one_hot_q = '0;
  assign bus.ack_valid_q   = 1'b0;
  assign bus.ack_index_q   = '0;
`endif

endmodule

// File: tb/tb_pe_lsb_first.sv
// tb_pe_lsb_first
//   Self-checking bench for pe_lsb_first (WIDTH=8). A per-cycle compare
//   process checks every output against an arithmetic reference
//   (lowest set bit = r & -r, index = log2 of that bit, registered copy =
//   previous-edge value or 0 in reset / when the register option is off).
//   Directed literal checks pin the reference and the extremes.
module tb_pe_lsb_first;

  localparam int WIDTH = 8;
  localparam int IW    = 3;
`ifdef PE_LSB_FOR_REG_OUT_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  bit checking = 1'b0;

  pe_lsb_first_if #(.WIDTH(WIDTH)) bus ();

  pe_lsb_first #(.WIDTH(WIDTH)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Reference model
  function automatic logic [7:0] m_oh(input logic [7:0] r);
    return r & (~r + 8'd1);
  endfunction

  function automatic logic [2:0] m_idx(input logic [7:0] r);
    logic [7:0] oh;
    oh = m_oh(r);
    if (oh == 8'd0) return 3'd0;
    return 3'($clog2(oh));
  endfunction

  logic [7:0] exp_oh_q  = '0;
  logic       exp_v_q   = 1'b0;
  logic [2:0] exp_idx_q = '0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST || !REG_EN) begin
      exp_oh_q  <= '0;
      exp_v_q   <= 1'b0;
      exp_idx_q <= '0;
    end else begin
      exp_oh_q  <= m_oh(bus.req_vec);
      exp_v_q   <= (bus.req_vec != 8'd0);
      exp_idx_q <= m_idx(bus.req_vec);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (req_vec=%02h nRST=%0b t=%0t)",
               name, act, exp, bus.req_vec, nRST, $time);
    end
  endtask

  // Per-cycle compare process
  always @(negedge CLK) begin
    if (checking) begin
      check("oh",    32'(bus.ack_one_hot),   32'(m_oh(bus.req_vec)));
      check("valid", 32'(bus.ack_valid),     32'(bus.req_vec != 8'd0));
      check("idx",   32'(bus.ack_index),     32'(m_idx(bus.req_vec)));
      check("oh_q",  32'(bus.ack_one_hot_q), 32'(exp_oh_q));
      check("v_q",   32'(bus.ack_valid_q),   32'(exp_v_q));
      check("idx_q", 32'(bus.ack_index_q),   32'(exp_idx_q));
    end
  end

  task automatic drive(input logic [7:0] v);
    @(posedge CLK);
    #1;
    bus.req_vec = v;
  endtask

  task automatic lit(input logic [7:0] v, input logic [7:0] oh, input logic [2:0] idx, input logic vld);
    drive(v);
    #1;
    $display("[TB] req=%02h oh=%02h idx=%0d valid=%0b", v, bus.ack_one_hot, bus.ack_index, bus.ack_valid);
    check("lit_oh",    32'(bus.ack_one_hot), 32'(oh));
    check("lit_idx",   32'(bus.ack_index),   32'(idx));
    check("lit_valid", 32'(bus.ack_valid),   32'(vld));
  endtask

  initial begin
    bus.req_vec = 8'h00;

    // Pin the model itself with hand-computed values.
    check("model_oh_A8",  32'(m_oh(8'hA8)),  32'h08);
    check("model_idx_A8", 32'(m_idx(8'hA8)), 32'd3);
    check("model_idx_80", 32'(m_idx(8'h80)), 32'd7);

    // Reset state
    repeat (2) @(posedge CLK);
    #2;
    check("rst_oh",   32'(bus.ack_one_hot),   32'h00);
    check("rst_v",    32'(bus.ack_valid),     32'h0);
    check("rst_oh_q", 32'(bus.ack_one_hot_q), 32'h00);
    check("rst_v_q",  32'(bus.ack_valid_q),   32'h0);
    check("rst_i_q",  32'(bus.ack_index_q),   32'h0);
    nRST = 1'b1;
    @(posedge CLK);
    #2;
    check("post_rst_oh_q", 32'(bus.ack_one_hot_q), 32'h00);
    check("post_rst_v",    32'(bus.ack_valid),     32'h0);
    checking = 1'b1;

    // Exhaustive sweep, one value per cycle
    for (int v = 0; v < 256; v++) drive(8'(v));
    $display("[TB] exhaustive sweep of 256 request values done");

    // Priority extremes
    lit(8'hFF, 8'h01, 3'd0, 1'b1);
    lit(8'h80, 8'h80, 3'd7, 1'b1);
    lit(8'hA8, 8'h08, 3'd3, 1'b1);
    lit(8'h00, 8'h00, 3'd0, 1'b0);

    // Registered path
    drive(8'h0C);
    drive(8'h30);
    #1;
    $display("[TB] reg path after 0C: oh_q=%02h", bus.ack_one_hot_q);
    check("regpath_0C", 32'(bus.ack_one_hot_q), REG_EN ? 32'h04 : 32'h00);
    drive(8'h00);
    #1;
    $display("[TB] reg path after 30: oh_q=%02h", bus.ack_one_hot_q);
    check("regpath_30", 32'(bus.ack_one_hot_q), REG_EN ? 32'h10 : 32'h00);

    // Reset mid-operation, between edges
    drive(8'h40);
    @(posedge CLK);
    #1;
    check("pre_midrst_oh_q", 32'(bus.ack_one_hot_q), REG_EN ? 32'h40 : 32'h00);
    #1;
    nRST = 1'b0;
    #1;
    $display("[TB] mid reset: oh=%02h oh_q=%02h", bus.ack_one_hot, bus.ack_one_hot_q);
    check("midrst_oh_q", 32'(bus.ack_one_hot_q), 32'h00);
    check("midrst_v_q",  32'(bus.ack_valid_q),   32'h0);
    check("midrst_i_q",  32'(bus.ack_index_q),   32'h0);
    check("midrst_oh",   32'(bus.ack_one_hot),   32'h40);
    drive(8'h16);
    #1;
    check("rst_live_oh", 32'(bus.ack_one_hot), 32'h02);
    @(posedge CLK);
    #2;
    nRST = 1'b1;

    // Randomized traffic with occasional reset pulses
    for (int n = 0; n < 400; n++) begin
      drive(8'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        #1 nRST = 1'b0;
        #2 nRST = 1'b1;
      end
    end
    $display("[TB] 400 random requests done");

    @(posedge CLK);
    #1;
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
